// File: rtl/calc_entry_ctrl.sv
// Operand-entry sequencer for the 6-bit signed add/subtract ALU: debounced enter/clear buttons,
// operand/operator capture and result latching. Define CALC_CHAIN_EN to chain results into operand 1.
module calc_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sw_value,
  input  logic       sw_op,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [5:0] alu_result,
  output logic [5:0] operand1,
  output logic [5:0] operand2,
  output logic       operator_select,
  output logic [5:0] result,
  output logic       result_valid,
  output logic       overflow,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  // Signed overflow from operand and result sign bits; op 1 = add, 0 = subtract.
  function automatic logic calc_ovf(input logic [5:0] a, input logic [5:0] b,
                                    input logic add, input logic [5:0] r);
    logic same_sign;
    same_sign = (a[5] == b[5]);
    if (add) begin
      calc_ovf = same_sign && (r[5] != a[5]);
    end else begin
      calc_ovf = !same_sign && (r[5] != a[5]);
    end
  endfunction

  logic             enter_meta_q, enter_sync_q, enter_db_q, enter_db_prev_q;
  logic             enter_meta_d, enter_sync_d, enter_db_d, enter_db_prev_d;
  logic [CNT_W-1:0] enter_cnt_q, enter_cnt_d;
  logic             clear_meta_q, clear_sync_q, clear_db_q, clear_db_prev_q;
  logic             clear_meta_d, clear_sync_d, clear_db_d, clear_db_prev_d;
  logic [CNT_W-1:0] clear_cnt_q, clear_cnt_d;
  logic             enter_press_s, clear_press_s;

  state_e     state_q, state_d;
  logic [5:0] operand1_q, operand1_d;
  logic [5:0] operand2_q, operand2_d;
  logic       operator_select_q, operator_select_d;
  logic [5:0] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic       overflow_q, overflow_d;

  // Synchroniser and debounce next-state for the enter button.
  always_comb begin
    enter_meta_d    = btn_enter;
    enter_sync_d    = enter_meta_q;
    enter_db_d      = enter_db_q;
    enter_cnt_d     = enter_cnt_q;
    enter_db_prev_d = enter_db_q;
    if (enter_sync_q != enter_db_q) begin
      if (enter_cnt_q == CNT_MAX) begin
        enter_db_d  = enter_sync_q;
        enter_cnt_d = {CNT_W{1'b0}};
      end else begin
        enter_cnt_d = enter_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      enter_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser and debounce next-state for the clear button.
  always_comb begin
    clear_meta_d    = btn_clear;
    clear_sync_d    = clear_meta_q;
    clear_db_d      = clear_db_q;
    clear_cnt_d     = clear_cnt_q;
    clear_db_prev_d = clear_db_q;
    if (clear_sync_q != clear_db_q) begin
      if (clear_cnt_q == CNT_MAX) begin
        clear_db_d  = clear_sync_q;
        clear_cnt_d = {CNT_W{1'b0}};
      end else begin
        clear_cnt_d = clear_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      clear_cnt_d = {CNT_W{1'b0}};
    end
  end

  assign enter_press_s = enter_db_q & ~enter_db_prev_q;
  assign clear_press_s = clear_db_q & ~clear_db_prev_q;

  // Button synchroniser, debounce and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_meta_q    <= 1'b0;
      enter_sync_q    <= 1'b0;
      enter_db_q      <= 1'b0;
      enter_db_prev_q <= 1'b0;
      enter_cnt_q     <= {CNT_W{1'b0}};
      clear_meta_q    <= 1'b0;
      clear_sync_q    <= 1'b0;
      clear_db_q      <= 1'b0;
      clear_db_prev_q <= 1'b0;
      clear_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      enter_meta_q    <= enter_meta_d;
      enter_sync_q    <= enter_sync_d;
      enter_db_q      <= enter_db_d;
      enter_db_prev_q <= enter_db_prev_d;
      enter_cnt_q     <= enter_cnt_d;
      clear_meta_q    <= clear_meta_d;
      clear_sync_q    <= clear_sync_d;
      clear_db_q      <= clear_db_d;
      clear_db_prev_q <= clear_db_prev_d;
      clear_cnt_q     <= clear_cnt_d;
    end
  end

  // Entry FSM next-state and datapath register updates; clear overrides enter.
  always_comb begin
    state_d           = state_q;
    operand1_d        = operand1_q;
    operand2_d        = operand2_q;
    operator_select_d = operator_select_q;
    result_d          = result_q;
    result_valid_d    = result_valid_q;
    overflow_d        = overflow_q;
    if (clear_press_s) begin
      state_d           = S_A;
      operand1_d        = 6'd0;
      operand2_d        = 6'd0;
      operator_select_d = 1'b0;
      result_d          = 6'd0;
      result_valid_d    = 1'b0;
      overflow_d        = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter_press_s) begin
            operand1_d = sw_value;
            state_d    = S_B;
          end else begin
            state_d = S_A;
          end
        end
        S_B: begin
          if (enter_press_s) begin
            operand2_d = sw_value;
            state_d    = S_OP;
          end else begin
            state_d = S_B;
          end
        end
        S_OP: begin
          if (enter_press_s) begin
            operator_select_d = sw_op;
            state_d           = S_EXEC;
          end else begin
            state_d = S_OP;
          end
        end
        S_EXEC: begin
          result_d       = alu_result;
          result_valid_d = 1'b1;
          overflow_d     = calc_ovf(operand1_q, operand2_q, operator_select_q, alu_result);
          state_d        = S_SHOW;
        end
        S_SHOW: begin
          if (enter_press_s) begin
`ifdef CALC_CHAIN_EN
            operand1_d = result_q;
            state_d    = S_B;
`else
            operand1_d = 6'd0;
            state_d    = S_A;
`endif
            operand2_d        = 6'd0;
            operator_select_d = 1'b0;
            result_valid_d    = 1'b0;
            overflow_d        = 1'b0;
          end else begin
            state_d = S_SHOW;
          end
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_A;
      operand1_q        <= 6'd0;
      operand2_q        <= 6'd0;
      operator_select_q <= 1'b0;
      result_q          <= 6'd0;
      result_valid_q    <= 1'b0;
      overflow_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      operand1_q        <= operand1_d;
      operand2_q        <= operand2_d;
      operator_select_q <= operator_select_d;
      result_q          <= result_d;
      result_valid_q    <= result_valid_d;
      overflow_q        <= overflow_d;
    end
  end

  assign operand1        = operand1_q;
  assign operand2        = operand2_q;
  assign operator_select = operator_select_q;
  assign result          = result_q;
  assign result_valid    = result_valid_q;
  assign overflow        = overflow_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl with DEBOUNCE_CYCLES=4 and a behavioural ALU.
module tb_calc_entry_ctrl;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sw_value = 6'd0;
  logic       sw_op = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [5:0] alu_result;
  logic [5:0] operand1, operand2, result;
  logic       operator_select, result_valid, overflow;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  calc_entry_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_value(sw_value), .sw_op(sw_op),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .alu_result(alu_result),
    .operand1(operand1), .operand2(operand2), .operator_select(operator_select),
    .result(result), .result_valid(result_valid), .overflow(overflow), .state_o(state_o)
  );

  assign alu_result = operator_select ? (operand1 + operand2) : (operand1 - operand2);

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic en, input logic cl);
    btn_enter = en;
    btn_clear = cl;
    tick(8);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(8);
  endtask

  task automatic do_calc(input logic [5:0] a, input logic [5:0] b, input logic op);
    sw_value = a;
    press(1'b1, 1'b0);
    sw_value = b;
    press(1'b1, 1'b0);
    sw_op = op;
    press(1'b1, 1'b0);
  endtask

  initial begin
    tick(2);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_op1", 32'(operand1), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    rst_n = 1'b1;
    tick(20);
    check_eq("idle_state", 32'(state_o), 32'd0);
    check_eq("idle_ovf", 32'(overflow), 32'd0);

    sw_value = 6'd5;
    press(1'b1, 1'b0);
    check_eq("a_op1", 32'(operand1), 32'd5);
    check_eq("a_state", 32'(state_o), 32'd1);
    sw_value = 6'd3;
    press(1'b1, 1'b0);
    check_eq("b_op2", 32'(operand2), 32'd3);
    check_eq("b_state", 32'(state_o), 32'd2);
    sw_op = 1'b1;
    press(1'b1, 1'b0);
    check_eq("add_opsel", 32'(operator_select), 32'd1);
    check_eq("add_result", 32'(result), 32'd8);
    check_eq("add_valid", 32'(result_valid), 32'd1);
    check_eq("add_ovf", 32'(overflow), 32'd0);
    check_eq("show_state", 32'(state_o), 32'd4);

    press(1'b1, 1'b0);
`ifdef CALC_CHAIN_EN
    check_eq("next_state", 32'(state_o), 32'd1);
    check_eq("next_op1", 32'(operand1), 32'd8);
`else
    check_eq("next_state", 32'(state_o), 32'd0);
    check_eq("next_op1", 32'(operand1), 32'd0);
`endif
    check_eq("next_valid", 32'(result_valid), 32'd0);
    check_eq("next_opsel", 32'(operator_select), 32'd0);

    press(1'b0, 1'b1);
    check_eq("clr_state", 32'(state_o), 32'd0);
    check_eq("clr_result", 32'(result), 32'd0);

    do_calc(6'd31, 6'd1, 1'b1);
    check_eq("ovf_add_res", 32'(result), 32'h20);
    check_eq("ovf_add_flag", 32'(overflow), 32'd1);
    press(1'b0, 1'b1);
    do_calc(6'h20, 6'd1, 1'b0);
    check_eq("ovf_sub_res", 32'(result), 32'h1F);
    check_eq("ovf_sub_flag", 32'(overflow), 32'd1);
    press(1'b0, 1'b1);
    do_calc(6'h3D, 6'd4, 1'b0);
    check_eq("neg_sub_res", 32'(result), 32'h39);
    check_eq("neg_sub_flag", 32'(overflow), 32'd0);
    check_eq("neg_sub_valid", 32'(result_valid), 32'd1);
    press(1'b0, 1'b1);
    check_eq("clr2_valid", 32'(result_valid), 32'd0);

    // Bouncy enter: short bursts must not register, final stable run registers once.
    sw_value = 6'd9;
    for (int i = 0; i < 4; i++) begin
      btn_enter = 1'b1;
      tick(3);
      btn_enter = 1'b0;
      tick(1);
    end
    btn_enter = 1'b1;
    tick(6);
    btn_enter = 1'b0;
    tick(10);
    check_eq("bounce_state", 32'(state_o), 32'd1);
    check_eq("bounce_op1", 32'(operand1), 32'd9);

    sw_value = 6'd12;
    btn_enter = 1'b1;
    tick(3);
    btn_enter = 1'b0;
    tick(10);
    check_eq("glitch_state", 32'(state_o), 32'd1);
    check_eq("glitch_op2", 32'(operand2), 32'd0);

    press(1'b1, 1'b0);
    check_eq("op_state", 32'(state_o), 32'd2);
    check_eq("op_op2", 32'(operand2), 32'd12);
    press(1'b1, 1'b1);
    check_eq("both_state", 32'(state_o), 32'd0);
    check_eq("both_op1", 32'(operand1), 32'd0);
    check_eq("both_op2", 32'(operand2), 32'd0);
    check_eq("both_valid", 32'(result_valid), 32'd0);

    sw_value = 6'd7;
    press(1'b1, 1'b0);
    check_eq("pre_rst_op1", 32'(operand1), 32'd7);
    btn_enter = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", 32'(state_o), 32'd0);
    check_eq("async_rst_op1", 32'(operand1), 32'd0);
    btn_enter = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_eq("post_rst_state", 32'(state_o), 32'd0);
    check_eq("post_rst_op1", 32'(operand1), 32'd0);

    // Button held across reset release yields exactly one press.
    rst_n = 1'b0;
    sw_value = 6'd21;
    btn_enter = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check_eq("held_state", 32'(state_o), 32'd1);
    check_eq("held_op1", 32'(operand1), 32'd21);
    btn_enter = 1'b0;
    tick(10);
    check_eq("held_op2", 32'(operand2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
